fifo_burst_reader: RTL and testbench

- Read-side master for the team's 8-bit synchronous FIFO.
- On a start pulse it pops exactly burst_len words from the FIFO through its rd_en/data_out/empty interface.
- The FIFO has one-cycle read latency. The block absorbs that latency in a 2-entry skid buffer and presents words on a valid/ready stream.
- It accumulates a word count and an XOR checksum, then pulses done. It is the consumer counterpart of the FIFO write path.

---
 rtl/fifo_burst_reader.sv | 170 +++++++++++++++++
 tb/tb_fifo_burst_reader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Read-side burst master for the 8-bit synchronous FIFO: pops burst_len words,
// absorbs the FIFO read latency in a 2-entry skid buffer, streams them out on valid/ready.
module fifo_burst_reader #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              busy,
  output logic              done,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic [LEN_W-1:0]  word_cnt,
  output logic [DATA_W-1:0] xor_sum
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
  logic [DATA_W-1:0] xor_sum_q, xor_sum_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] buf0_q, buf0_d;
  logic [DATA_W-1:0] buf1_q, buf1_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept_s;
  logic              rd_en_s;

  assign m_valid  = (occ_q != 2'd0);
  assign m_data   = buf0_q;
  assign accept_s = m_valid && m_ready;

  // A pop is only issued when the word it returns is guaranteed a buffer slot.
  assign rd_en_s = (state_q == S_READ) && !fifo_empty && (issued_q < len_q) &&
                   (({1'b0, inflight_q} + occ_q) < 2'd2);

  assign fifo_rd_en = rd_en_s;
  assign busy       = busy_q;
  assign done       = done_q;
  assign word_cnt   = word_cnt_q;
  assign xor_sum    = xor_sum_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    word_cnt_d = word_cnt_q;
    xor_sum_d  = xor_sum_q;
    inflight_d = rd_en_s;
    occ_d      = occ_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;

    // Skid buffer: buf0 is always the head; capture and accept may coincide.
    case ({inflight_q, accept_s})
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = fifo_data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_data;
        end
      end
      2'b10: begin
        case (occ_q)
          2'd0:    buf0_d = fifo_data;
          2'd1:    buf1_d = fifo_data;
          default: buf1_d = buf1_q;
        endcase
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      default: occ_d = occ_q;
    endcase

    if (accept_s) begin
      word_cnt_d = word_cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
      xor_sum_d  = xor_sum_q ^ buf0_q;
    end else begin
      word_cnt_d = word_cnt_q;
    end

    if (rd_en_s) begin
      issued_d = issued_q + {{(LEN_W-1){1'b0}}, 1'b1};
    end else begin
      issued_d = issued_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d      = burst_len;
          issued_d   = {LEN_W{1'b0}};
          word_cnt_d = {LEN_W{1'b0}};
          xor_sum_d  = {DATA_W{1'b0}};
          state_d    = (burst_len == {LEN_W{1'b0}}) ? S_DONE : S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (issued_q == len_q) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_READ;
        end
      end
      S_DRAIN: begin
        if (word_cnt_q == len_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // All state, including the registered busy/done flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= {LEN_W{1'b0}};
      issued_q   <= {LEN_W{1'b0}};
      word_cnt_q <= {LEN_W{1'b0}};
      xor_sum_q  <= {DATA_W{1'b0}};
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      buf0_q     <= {DATA_W{1'b0}};
      buf1_q     <= {DATA_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      word_cnt_q <= word_cnt_d;
      xor_sum_q  <= xor_sum_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural one-cycle-latency FIFO
// and a stream monitor; expected values are hand-computed per scenario.
module tb_fifo_burst_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] burst_len = 8'd0;
  logic       busy, done;
  logic       fifo_empty = 1'b1;
  logic       fifo_rd_en;
  logic [7:0] fifo_data = 8'd0;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready = 1'b0;
  logic [7:0] word_cnt, xor_sum;

  logic [7:0] fifo_q[$];
  logic [7:0] pend_q[$];
  logic [7:0] rcv[$];
  int rd_cnt = 0, underflow = 0, done_cnt = 0, rcv_at_done = 0;
  int n_cmp = 0, n_err = 0;

  fifo_burst_reader dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
    .busy(busy), .done(done), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_data(fifo_data), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .word_cnt(word_cnt), .xor_sum(xor_sum)
  );

  always #5 clk = ~clk;

  // FIFO model (pop with one-cycle latency, pending writes land at the edge) and monitor.
  always @(posedge clk) begin
    if (rst) begin
      fifo_q.delete();
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_rd_en) begin
        rd_cnt <= rd_cnt + 1;
        if (fifo_empty) underflow <= underflow + 1;
        else fifo_data <= fifo_q.pop_front();
      end
      while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
      fifo_empty <= (fifo_q.size() == 0);
      if (m_valid && m_ready) rcv.push_back(m_data);
      if (done) begin
        done_cnt    <= done_cnt + 1;
        rcv_at_done <= rcv.size();
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    pend_q.push_back(v);
  endtask

  task automatic do_start(input logic [7:0] len);
    start = 1'b1;
    burst_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done, then checks busy drops on the following cycle.
  task automatic wait_done(input string tag, input int budget);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    @(negedge clk);
    check_eq({tag, "_done_low"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_beats(input string tag, input int base, input logic [7:0] exp[$]);
    logic [7:0] got;
    for (int i = 0; i < exp.size(); i++) begin
      got = (base + i < rcv.size()) ? rcv[base + i] : 8'hxx;
      check_eq($sformatf("%s_beat%0d", tag, i), {24'd0, got}, {24'd0, exp[i]});
    end
    check_eq({tag, "_nbeats"}, rcv.size() - base, exp.size());
  endtask

  initial begin
    int b_rd, b_rcv, b_done;
    logic saw_done, unstable;
    logic [7:0] exp[$];

    repeat (3) @(negedge clk);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check_eq("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check_eq("rst_m_data", {24'd0, m_data}, 32'd0);
    check_eq("rst_word_cnt", {24'd0, word_cnt}, 32'd0);
    check_eq("rst_xor_sum", {24'd0, xor_sum}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: full 8-word burst, always ready
    exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    foreach (exp[i]) push(exp[i]);
    m_ready = 1'b1;
    @(negedge clk);
    b_rd = rd_cnt; b_rcv = rcv.size(); b_done = done_cnt;
    do_start(8'd8);
    wait_done("t1", 200);
    check_beats("t1", b_rcv, exp);
    check_eq("t1_rd_cnt", rd_cnt - b_rd, 32'd8);
    check_eq("t1_done_cnt", done_cnt - b_done, 32'd1);
    check_eq("t1_word_cnt", {24'd0, word_cnt}, 32'd8);
    check_eq("t1_xor_sum", {24'd0, xor_sum}, 32'h88);
    repeat (3) @(negedge clk);
    check_eq("t1_word_cnt_hold", {24'd0, word_cnt}, 32'd8);

    // 2: FIFO runs dry mid-burst, refilled 10 cycles later
    exp = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    push(8'hA1); push(8'hA2); push(8'hA3);
    b_rd = rd_cnt; b_rcv = rcv.size(); b_done = done_cnt;
    do_start(8'd5);
    saw_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check_eq("t2_no_early_done", {31'd0, saw_done}, 32'd0);
    check_eq("t2_beats_while_dry", rcv.size() - b_rcv, 32'd3);
    push(8'hA4); push(8'hA5);
    wait_done("t2", 200);
    check_beats("t2", b_rcv, exp);
    check_eq("t2_rd_cnt", rd_cnt - b_rd, 32'd5);
    check_eq("t2_done_after_last", rcv_at_done - b_rcv, 32'd5);
    check_eq("t2_underflow", underflow, 32'd0);

    // 3: downstream stalled for 6 cycles
    exp = '{8'h31, 8'h32, 8'h33, 8'h34};
    foreach (exp[i]) push(exp[i]);
    m_ready = 1'b0;
    @(negedge clk);
    b_rd = rd_cnt; b_rcv = rcv.size();
    do_start(8'd4);
    unstable = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (m_valid && m_data !== 8'h31) unstable = 1'b1;
    end
    check_eq("t3_pops_stalled", rd_cnt - b_rd, 32'd2);
    check_eq("t3_valid_stalled", {31'd0, m_valid}, 32'd1);
    check_eq("t3_data_stable", {31'd0, unstable}, 32'd0);
    m_ready = 1'b1;
    wait_done("t3", 200);
    check_beats("t3", b_rcv, exp);
    check_eq("t3_underflow", underflow, 32'd0);

    // 4: zero-length burst
    b_rd = rd_cnt; b_done = done_cnt;
    do_start(8'd0);
    check_eq("t4_done_pulse", {31'd0, done}, 32'd1);
    wait_done("t4", 4);
    check_eq("t4_rd_cnt", rd_cnt - b_rd, 32'd0);
    check_eq("t4_done_cnt", done_cnt - b_done, 32'd1);
    check_eq("t4_word_cnt", {24'd0, word_cnt}, 32'd0);
    check_eq("t4_xor_sum", {24'd0, xor_sum}, 32'd0);

    // 5: reset after 3 accepted words, then a fresh 2-word burst
    for (int i = 1; i <= 8; i++) push(8'(i));
    @(negedge clk);
    b_rcv = rcv.size(); b_done = done_cnt;
    do_start(8'd8);
    for (int i = 0; i < 100; i++) begin
      if (rcv.size() - b_rcv >= 3) break;
      @(negedge clk);
    end
    check_eq("t5_three_beats", rcv.size() - b_rcv, 32'd3);
    rst = 1'b1;
    #1;
    check_eq("t5_busy", {31'd0, busy}, 32'd0);
    check_eq("t5_done", {31'd0, done}, 32'd0);
    check_eq("t5_m_valid", {31'd0, m_valid}, 32'd0);
    check_eq("t5_m_data", {24'd0, m_data}, 32'd0);
    check_eq("t5_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check_eq("t5_word_cnt", {24'd0, word_cnt}, 32'd0);
    check_eq("t5_xor_sum", {24'd0, xor_sum}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("t5_no_done", done_cnt - b_done, 32'd0);
    exp = '{8'h5A, 8'hA5};
    push(8'h5A); push(8'hA5);
    @(negedge clk);
    b_rcv = rcv.size();
    do_start(8'd2);
    wait_done("t5b", 100);
    check_beats("t5b", b_rcv, exp);
    check_eq("t5b_word_cnt", {24'd0, word_cnt}, 32'd2);
    check_eq("t5b_xor_sum", {24'd0, xor_sum}, 32'hFF);

    // 6: start pulsed again while busy is ignored
    exp = '{8'hC1, 8'hC2, 8'hC3};
    foreach (exp[i]) push(exp[i]);
    m_ready = 1'b0;
    @(negedge clk);
    b_rd = rd_cnt; b_rcv = rcv.size(); b_done = done_cnt;
    do_start(8'd3);
    repeat (2) @(negedge clk);
    check_eq("t6_busy", {31'd0, busy}, 32'd1);
    do_start(8'd7);
    m_ready = 1'b1;
    wait_done("t6", 200);
    check_beats("t6", b_rcv, exp);
    check_eq("t6_rd_cnt", rd_cnt - b_rd, 32'd3);
    check_eq("t6_done_cnt", done_cnt - b_done, 32'd1);
    check_eq("t6_word_cnt", {24'd0, word_cnt}, 32'd3);
    check_eq("t6_xor_sum", {24'd0, xor_sum}, 32'hC0);
    check_eq("final_underflow", underflow, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
